// File: rtl/mesh_run_controller.sv
// mesh_run_controller: launches a traffic run, times it against a budget, then streams every node's PMU registers out in node-major order
module mesh_run_controller #(
  parameter int NODES = 16,
  parameter int PMU_ADDR_W = 5,
  parameter int PMU_DATA_W = 64,
  parameter int PMU_REGS = 16,
  parameter int CNT_W = 32,
  localparam int NODE_W = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        run_i,
  input  logic [CNT_W-1:0]            timeout_i,
  output logic                        start_o,
  input  logic [NODES-1:0]            idle_i,
  output logic [PMU_ADDR_W-1:0]       pmu_addr_o,
  input  logic [NODES*PMU_DATA_W-1:0] pmu_data_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        timeout_o,
  output logic [CNT_W-1:0]            cycles_o,
  output logic                        rd_valid_o,
  input  logic                        rd_ready_i,
  output logic [PMU_DATA_W-1:0]       rd_data_o,
  output logic [NODE_W-1:0]           rd_node_o,
  output logic [PMU_ADDR_W-1:0]       rd_reg_o,
  output logic                        rd_last_o
);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_SETTLE = 3'd2, S_RUN = 3'd3,
                         S_SCAN_ADDR = 3'd4, S_SCAN_OUT = 3'd5, S_DONE = 3'd6;
  localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NODES - 1);
  localparam logic [PMU_ADDR_W-1:0] LAST_REG = PMU_ADDR_W'(PMU_REGS - 1);
  logic [2:0] state;
  logic [CNT_W-1:0] cnt, budget, cnt_inc;
  logic [NODE_W-1:0] node_idx, node_nxt;
  logic [PMU_ADDR_W-1:0] reg_idx, reg_nxt;
  logic all_idle, budget_hit, reg_wrap, last_beat;
  assign start_o = state == S_START;
  assign busy_o = state != S_IDLE;
  assign done_o = state == S_DONE;
  assign rd_valid_o = state == S_SCAN_OUT;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign all_idle = &idle_i;
  assign budget_hit = budget != '0 && cnt_inc >= budget;
  assign reg_wrap = reg_idx == LAST_REG;
  assign reg_nxt = reg_wrap ? '0 : reg_idx + 1'b1;
  assign node_nxt = reg_wrap ? node_idx + 1'b1 : node_idx;
  assign last_beat = reg_wrap && node_idx == LAST_NODE;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_IDLE;
      cnt <= '0;
      budget <= '0;
      node_idx <= '0;
      reg_idx <= '0;
      pmu_addr_o <= '0;
      timeout_o <= 1'b0;
      cycles_o <= '0;
      rd_data_o <= '0;
      rd_node_o <= '0;
      rd_reg_o <= '0;
      rd_last_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (run_i) begin
          budget <= timeout_i;
          cnt <= '0;
          cycles_o <= '0;
          timeout_o <= 1'b0;
          state <= S_START;
        end
        S_START: begin
          cnt <= CNT_W'(1);
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          cnt <= cnt_inc;
          state <= cnt == CNT_W'(2) ? S_RUN : S_SETTLE;
        end
        S_RUN: begin
          cnt <= cnt_inc;
          if (all_idle || budget_hit) begin
            cycles_o <= cnt_inc;
            timeout_o <= !all_idle;
            node_idx <= '0;
            reg_idx <= '0;
            pmu_addr_o <= '0;
            state <= S_SCAN_ADDR;
          end
        end
        S_SCAN_ADDR: begin
          rd_data_o <= pmu_data_i[int'(node_idx)*PMU_DATA_W +: PMU_DATA_W];
          rd_node_o <= node_idx;
          rd_reg_o <= reg_idx;
          rd_last_o <= last_beat;
          state <= S_SCAN_OUT;
        end
        S_SCAN_OUT: if (rd_ready_i) begin
          reg_idx <= reg_nxt;
          node_idx <= node_nxt;
          pmu_addr_o <= reg_nxt;
          state <= last_beat ? S_DONE : S_SCAN_ADDR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mesh_run_controller.sv
// tb_mesh_run_controller: randomized run/readout sequences checked against a cycle-counting reference model
module tb_mesh_run_controller;
  localparam int NODES = 16, AW = 5, DW = 64, REGS = 16, CW = 32, NW = 4;
  logic aclk = 1'b0, aresetn = 1'b0, run_i = 1'b0, rd_ready_i = 1'b0;
  logic [CW-1:0] timeout_i = '0;
  logic [NODES-1:0] idle_i = '0;
  logic [NODES*DW-1:0] pmu_data_i;
  logic start_o, busy_o, done_o, timeout_o, rd_valid_o, rd_last_o;
  logic [AW-1:0] pmu_addr_o, rd_reg_o;
  logic [CW-1:0] cycles_o;
  logic [DW-1:0] rd_data_o;
  logic [NW-1:0] rd_node_o;
  logic [31:0] salt = '0;
  int vectors = 0, errs = 0;
  mesh_run_controller #(.NODES(NODES), .PMU_ADDR_W(AW), .PMU_DATA_W(DW), .PMU_REGS(REGS), .CNT_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .run_i(run_i), .timeout_i(timeout_i), .start_o(start_o),
    .idle_i(idle_i), .pmu_addr_o(pmu_addr_o), .pmu_data_i(pmu_data_i), .busy_o(busy_o),
    .done_o(done_o), .timeout_o(timeout_o), .cycles_o(cycles_o), .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .rd_node_o(rd_node_o), .rd_reg_o(rd_reg_o),
    .rd_last_o(rd_last_o)
  );
  always #5 aclk = ~aclk;
  always_comb for (int n = 0; n < NODES; n++) pmu_data_i[n*DW +: DW] = {salt, 16'(n), 16'(pmu_addr_o)};
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(string tag);
    chk(tag, {start_o, busy_o, done_o, timeout_o, cycles_o, rd_valid_o, rd_last_o, rd_node_o, rd_reg_o, pmu_addr_o}, '0);
    chk({tag, "_data"}, rd_data_o, '0);
  endtask
  task automatic do_run(int idle_at, logic [NODES-1:0] stuck, logic [CW-1:0] budget);
    int k, e;
    bit to;
    e = 0;
    for (int c = 4; c < 2000 && e == 0; c++)
      if ((c >= idle_at && stuck == '0) || (budget != 0 && c >= budget)) e = c;
    to = !(e >= idle_at && stuck == '0);
    salt = $urandom;
    timeout_i = budget;
    run_i = 1'b1;
    @(negedge aclk);
    run_i = 1'b0;
    timeout_i = $urandom;
    k = 1;
    chk("start_pulse", {start_o, busy_o}, 2'b11);
    chk("run_clear", {timeout_o, cycles_o}, '0);
    idle_i = (k >= idle_at) ? ~stuck : '0;
    while (k < e) begin
      @(negedge aclk);
      k++;
      idle_i = (k >= idle_at) ? ~stuck : '0;
      run_i = 1'($urandom);
      chk("no_restart", {start_o, busy_o, rd_valid_o}, 3'b010);
    end
    @(negedge aclk);
    run_i = 1'b0;
    chk("cycles", cycles_o, e);
    chk("timeout", timeout_o, to);
  endtask
  task automatic scan(int stall_beat, int rst_beat, bit rnd);
    logic [DW-1:0] ed;
    int t;
    for (int b = 0; b < NODES*REGS; b++) begin
      ed = {salt, 16'(b / REGS), 16'(b % REGS)};
      t = 0;
      while (!rd_valid_o && t < 8) begin
        @(negedge aclk);
        t++;
      end
      chk("beat_valid", rd_valid_o, 1'b1);
      chk("beat_fields", {rd_node_o, rd_reg_o, rd_last_o, done_o}, {4'(b / REGS), 5'(b % REGS), b == NODES*REGS-1, 1'b0});
      chk("beat_data", rd_data_o, ed);
      if (b == rst_beat) begin
        aresetn = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk_zero("post_reset");
        return;
      end
      if (b == stall_beat) begin
        rd_ready_i = 1'b0;
        repeat (10) begin
          @(negedge aclk);
          chk("stall_hold", {rd_valid_o, rd_node_o, rd_reg_o, rd_data_o}, {1'b1, 4'(b / REGS), 5'(b % REGS), ed});
        end
      end
      while (rnd && $urandom_range(0, 2) == 0) begin
        rd_ready_i = 1'b0;
        @(negedge aclk);
        chk("wait_hold", {rd_valid_o, rd_data_o}, {1'b1, ed});
      end
      rd_ready_i = 1'b1;
      @(negedge aclk);
      rd_ready_i = rnd ? 1'($urandom) : 1'b0;
      chk("valid_drop", rd_valid_o, 1'b0);
      if (b == NODES*REGS-1) begin
        chk("done_pulse", {done_o, busy_o}, 2'b11);
        @(negedge aclk);
        rd_ready_i = 1'b0;
        chk("done_end", {done_o, busy_o}, 2'b00);
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge aclk);
    chk_zero("reset");
    aresetn = 1'b1;
    @(negedge aclk);
    chk_zero("reset_release");
    do_run(40, '0, 0);
    scan(-1, -1, 1'b0);
    do_run(1, 16'h0080, 100);
    scan(-1, -1, 1'b1);
    do_run(50, '0, 50);
    scan(5, -1, 1'b1);
    do_run(1, '0, 0);
    scan(-1, 30, 1'b1);
    repeat (3) begin
      int ia;
      logic [NODES-1:0] st;
      logic [CW-1:0] bg;
      ia = $urandom_range(1, 60);
      st = $urandom_range(0, 1) ? '0 : NODES'(1) << $urandom_range(0, NODES-1);
      bg = $urandom_range(0, 80);
      if (st != '0 && bg == 0) bg = 7;
      do_run(ia, st, bg);
      scan(-1, -1, 1'b1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/mesh_run_controller.md
Name: mesh_run_controller

Overview:
- Parametrised run sequencer for the loader/PMU/mesh cosimulation top, generalised to NODES traffic nodes.
- Launches one traffic run to all loaders, waits for global idle or a cycle-budget timeout, and records run length.
- Then scans PMU_REGS counters from every node's PMU and streams them out as a valid/ready stream.
- Replaces host-side polling of per-node PMU ports with a single ordered readout.

Parameters:
- NODES, 16, number of loader/PMU nodes; NODE_W = max(1,$clog2(NODES)) derived.
- PMU_ADDR_W, 5, PMU register address width.
- PMU_DATA_W, 64, PMU register data width.
- PMU_REGS, 16, registers scanned per node, addresses 0..PMU_REGS-1, at most 2**PMU_ADDR_W.
- CNT_W, 32, width of the run cycle counter and timeout budget.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- run_i  in  1  run request, sampled only in IDLE.
- timeout_i  in  CNT_W  cycle budget, sampled on run acceptance; 0 = no timeout.
- start_o  out  1  one-cycle start pulse, broadcast to all loaders.
- idle_i  in  NODES  per-loader idle flags.
- pmu_addr_o  out  PMU_ADDR_W  PMU register address, broadcast to all nodes.
- pmu_data_i  in  NODES*PMU_DATA_W  packed PMU read data; node n at [n*PMU_DATA_W +: PMU_DATA_W]; combinational from pmu_addr_o.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at end of readout.
- timeout_o  out  1  last run hit the budget; holds until next run is accepted.
- cycles_o  out  CNT_W  run length of last run; holds until next run is accepted.
- rd_valid_o  out  1  readout beat valid.
- rd_ready_i  in  1  readout beat accepted.
- rd_data_o  out  PMU_DATA_W  PMU register value.
- rd_node_o  out  NODE_W  node index of the beat.
- rd_reg_o  out  PMU_ADDR_W  register index of the beat.
- rd_last_o  out  1  final beat of the scan.

Behaviour:
- Reset (async, any state): FSM=IDLE; all outputs 0; counters, indices and timeout latch cleared.
- States: IDLE, START, SETTLE, RUN, SCAN_ADDR, SCAN_OUT, DONE.
- IDLE: on run_i=1, latch timeout_i, clear cnt, cycles_o and timeout_o, then go to START. run_i in any other state is ignored.
- START: start_o=1 for exactly this cycle; cnt=1; go to SETTLE.
- SETTLE: 2 cycles (cnt increments) so loaders can leave idle; idle_i is ignored; go to RUN.
- RUN: cnt increments every cycle, saturating at all-ones.
  - If &idle_i=1: cycles_o=cnt, go to SCAN_ADDR.
  - Else, if budget!=0 and cnt>=budget: cycles_o=cnt, timeout_o=1, go to SCAN_ADDR.
  - Idle has priority over timeout on the same cycle, so timeout_o stays 0.
  - A loader that never leaves idle still ends the run, at cnt=3 (1+2 settle), yielding cycles_o=4.
- SCAN order: node 0 regs 0..PMU_REGS-1, then node 1, … up to node NODES-1; PMU_REGS*NODES beats total.
- SCAN_ADDR: drive pmu_addr_o=reg idx for 1 cycle; go to SCAN_OUT.
- SCAN_OUT:
  - Entry edge registers rd_data_o from the current node's pmu_data_i slice, plus rd_node_o and rd_reg_o; rd_valid_o=1.
  - rd_last_o=1 iff node=NODES-1 and reg=PMU_REGS-1.
  - Beat holds stable while rd_valid_o=1 and rd_ready_i=0, indefinitely.
  - On handshake: rd_valid_o=0 next cycle; advance reg, wrapping to 0 and incrementing node. Last beat goes to DONE, others to SCAN_ADDR.
  - Throughput is 1 beat per 2 cycles.
- pmu_addr_o holds its last value outside SCAN_ADDR.
- DONE: done_o=1 for one cycle; go to IDLE. cycles_o and timeout_o persist.
- rd_ready_i outside SCAN_OUT has no effect.

Test Plan:
- Reset with NODES=16, PMU_REGS=16: all outputs 0. run_i=1 at cycle 0 → start_o high only at cycle 1; busy_o high from cycle 1.
- Run where all loaders go idle at cnt=40, budget 0 → cycles_o=40, timeout_o=0. Then 256 beats with rd_ready_i=1 at node0/reg0, node0/reg1, …, node15/reg15. Only the last beat has rd_last_o=1, followed by one done_o pulse.
- Node 7 never goes idle, timeout_i=100 → cycles_o=100, timeout_o=1, scan proceeds normally.
- Idle and cnt>=budget on the same cycle (timeout_i=50, idle at cnt=50) → timeout_o=0, cycles_o=50.
- PMU model returns {node,reg} in data; hold rd_ready_i=0 for 10 cycles on beat 5 → data, node and reg stay stable. Each beat's rd_data_o encodes its own rd_node_o and rd_reg_o.
- Assert aresetn=0 mid-SCAN (beat 30) and release → back in IDLE with all outputs 0. run_i during RUN ignored: no second start_o.
